// File: rtl/o_buffer_acc_stream_if.sv
// Stream bundle for o_buffer_acc_stream: array-side beat input and
// writeback-side readout with valid/ready.
interface o_buffer_acc_stream_if #(
    parameter int ARRAY_M    = 8,
    parameter int DATA_WIDTH = 32
);
    logic                            in_valid;
    logic [ARRAY_M*DATA_WIDTH-1:0]   data_set_in;
    logic                            rd_valid;
    logic                            rd_ready;
    logic [DATA_WIDTH-1:0]           rd_data;
    logic                            rd_last;

    // driver side: array edge + downstream consumer
    modport master (
        output in_valid, data_set_in, rd_ready,
        input  rd_valid, rd_data, rd_last
    );

    // buffer side
    modport slave (
        input  in_valid, data_set_in, rd_ready,
        output rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/o_buffer_acc_stream.sv
// Systolic-array output buffer: per-column DEPTH-row store filled with
// accumulate (WS) or overwrite (OS) beats, drained row-major as a stream.
// Optional macro O_BUF_ACC_SAT_EN: WS add saturates instead of wrapping.

// One column of the store with its two-stage write pipeline.
module o_buf_col #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ROW_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  beat_vld,
    input  logic [ROW_W-1:0]      beat_row,
    input  logic [DATA_WIDTH-1:0] beat_data,
    input  logic                  ovr,
    input  logic [ROW_W-1:0]      rd_row,
    output logic [DATA_WIDTH-1:0] rd_word
);
    typedef struct packed {
        logic                  vld;
        logic                  ovr;
        logic [ROW_W-1:0]      row;
        logic [DATA_WIDTH-1:0] din;
        logic [DATA_WIDTH-1:0] old;
    } wr_req_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    wr_req_t               wr_q;
    logic [DATA_WIDTH-1:0] wr_val;
    logic [DATA_WIDTH-1:0] old_rd;

    function automatic logic [DATA_WIDTH-1:0] acc_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] s;
        s = a + b;
`ifdef O_BUF_ACC_SAT_EN
        // same-sign operands producing an opposite-sign result overflowed
        if (a[DATA_WIDTH-1] == b[DATA_WIDTH-1] && s[DATA_WIDTH-1] != a[DATA_WIDTH-1])
            s = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
        return s;
    endfunction

    assign wr_val  = wr_q.ovr ? wr_q.din : acc_add(wr_q.old, wr_q.din);
    // a beat that reads the row being written this cycle must see the new sum
    assign old_rd  = (wr_q.vld && wr_q.row == beat_row) ? wr_val : mem[beat_row];
    assign rd_word = mem[rd_row];

    // stage 1: capture beat together with its (forwarded) old value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_q <= '0;
        else       wr_q <= '{beat_vld, ovr, beat_row, beat_data, old_rd};
    end

    // stage 2: retire into the store (contents not reset)
    always_ff @(posedge clk) begin
        if (wr_q.vld) mem[wr_q.row] <= wr_val;
    end
endmodule

module o_buffer_acc_stream #(
    parameter int ARRAY_M    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ROW_W      = $clog2(DEPTH),
    parameter int COL_W      = $clog2(ARRAY_M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             first_pass,
    input  logic [COL_W:0]   num_cols,
    input  logic [ROW_W:0]   num_rows,
    input  logic             drain_req,
    o_buffer_acc_stream_if.slave s,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DRAIN} state_t;

    state_t                              state_q, state_d;
    logic                                mode_q, first_q;
    logic [COL_W:0]                      ncols_q, last_col;
    logic [ROW_W:0]                      nrows_q, last_row;
    logic [ROW_W-1:0]                    wr_row_q, rd_row_q;
    logic [COL_W-1:0]                    rd_col_q;
    logic                                pend_q;
    logic                                rd_valid_q, rd_last_q, done_q, err_q;
    logic [DATA_WIDTH-1:0]               rd_data_q;
    logic                                beat_ok, fire, load, at_last;
    logic [ARRAY_M-1:0][DATA_WIDTH-1:0]  din_v, col_words;

    assign din_v    = s.data_set_in;
    assign beat_ok  = s.in_valid && state_q == FILL;
    assign last_row = nrows_q - (ROW_W+1)'(1);
    assign last_col = ncols_q - (COL_W+1)'(1);
    assign fire     = rd_valid_q && s.rd_ready;
    assign load     = state_q == DRAIN && pend_q && (!rd_valid_q || s.rd_ready);
    assign at_last  = {1'b0, rd_row_q} == last_row && {1'b0, rd_col_q} == last_col;

    generate
        for (genvar c = 0; c < ARRAY_M; c++) begin : g_col
            o_buf_col #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ROW_W(ROW_W)) u_col (
                .clk      (clk),
                .reset    (reset),
                .beat_vld (beat_ok && (COL_W+1)'(c) < ncols_q),
                .beat_row (wr_row_q),
                .beat_data(din_v[c]),
                .ovr      (mode_q | first_q),
                .rd_row   (rd_row_q),
                .rd_word  (col_words[c])
            );
        end
    endgenerate

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)                state_d = FILL;
            FILL:    if (drain_req)            state_d = FLUSH;
            FLUSH:                             state_d = DRAIN;
            DRAIN:   if (fire && rd_last_q)    state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // tile config capture, fill row pointer and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= 1'b0;
            first_q  <= 1'b0;
            ncols_q  <= '0;
            nrows_q  <= '0;
            wr_row_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                mode_q   <= mode;
                first_q  <= first_pass;
                ncols_q  <= num_cols;
                nrows_q  <= num_rows;
                wr_row_q <= '0;
                err_q    <= 1'b0;
            end
            if (s.in_valid && state_q != FILL) err_q <= 1'b1;
            if (beat_ok)
                wr_row_q <= ({1'b0, wr_row_q} == last_row) ? '0 : wr_row_q + ROW_W'(1);
        end
    end

    // readout: row-major walk, registered output slot, done on last accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            pend_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= fire && rd_last_q;
            if (state_q == FLUSH) begin
                rd_row_q <= '0;
                rd_col_q <= '0;
                pend_q   <= 1'b1;
            end
            if (load) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= col_words[rd_col_q];
                rd_last_q  <= at_last;
                if (at_last) pend_q <= 1'b0;
                if ({1'b0, rd_col_q} == last_col) begin
                    rd_col_q <= '0;
                    rd_row_q <= rd_row_q + ROW_W'(1);
                end else begin
                    rd_col_q <= rd_col_q + COL_W'(1);
                end
            end else if (fire) begin
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end
        end
    end

    assign s.rd_valid = rd_valid_q;
    assign s.rd_data  = rd_data_q;
    assign s.rd_last  = rd_last_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign err        = err_q;
endmodule
